// File: rtl/ofmap_check_ctrl.sv
// Compares an ofmap stream against golden memory word by word; 3 cycles per word (fetch, wait, compare).
// Backpressure: out_ready is high only in COMPARE and the FSM holds there until out_valid arrives.
module ofmap_check_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic                  out_valid,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ready,
    output logic                  gold_rd_en,
    output logic [ADDR_WIDTH-1:0] gold_addr,
    input  logic [DATA_WIDTH-1:0] gold_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  first_err_valid,
    output logic [ADDR_WIDTH-1:0] first_err_index,
    output logic [DATA_WIDTH-1:0] first_err_out,
    output logic [DATA_WIDTH-1:0] first_err_exp
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  ONE_C = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_num_words;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0] r_gold_q;
    logic [CNT_WIDTH-1:0]  r_match;
    logic [CNT_WIDTH-1:0]  r_mismatch;
    logic                  r_fe_vld;
    logic [ADDR_WIDTH-1:0] r_fe_idx;
    logic [DATA_WIDTH-1:0] r_fe_out;
    logic [DATA_WIDTH-1:0] r_fe_exp;

    logic                  w_accept;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_equal;
    logic                  w_out_ready;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_busy;
    logic                  w_done;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_hs     = (r_state == S_COMPARE) && out_valid;
    assign w_last   = (r_idx == (r_num_words - ONE_A));
    assign w_equal  = (out_data == r_gold_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every output below is a pure decode of r_state (plus registered idx), never of out_valid.
    always_comb begin
        w_next      = r_state;
        w_out_ready = 1'b0;
        w_rd_en     = 1'b0;
        w_addr      = '0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_next = (num_words == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_rd_en = 1'b1;
                w_addr  = r_idx;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                w_next = S_COMPARE;
            end
            S_COMPARE: begin
                w_out_ready = 1'b1;
                if (out_valid) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_words <= '0;
            r_idx       <= '0;
            r_gold_q    <= '0;
            r_match     <= '0;
            r_mismatch  <= '0;
            r_fe_vld    <= 1'b0;
            r_fe_idx    <= '0;
            r_fe_out    <= '0;
            r_fe_exp    <= '0;
        end else if (w_accept) begin
            r_num_words <= num_words;
            r_idx       <= '0;
            r_match     <= '0;
            r_mismatch  <= '0;
            r_fe_vld    <= 1'b0;
            r_fe_idx    <= '0;
            r_fe_out    <= '0;
            r_fe_exp    <= '0;
        end else begin
            if (r_state == S_WAIT) begin
                r_gold_q <= gold_rd_data;
            end
            if (w_hs) begin
                if (w_equal) begin
                    if (r_match != CNT_MAX) begin
                        r_match <= r_match + ONE_C;
                    end
                end else begin
                    if (r_mismatch != CNT_MAX) begin
                        r_mismatch <= r_mismatch + ONE_C;
                    end
                    // Only the first mismatch of a run is kept for debug.
                    if (!r_fe_vld) begin
                        r_fe_vld <= 1'b1;
                        r_fe_idx <= r_idx;
                        r_fe_out <= out_data;
                        r_fe_exp <= r_gold_q;
                    end
                end
                if (!w_last) begin
                    r_idx <= r_idx + ONE_A;
                end
            end
        end
    end

    assign out_ready       = w_out_ready;
    assign gold_rd_en      = w_rd_en;
    assign gold_addr       = w_addr;
    assign busy            = w_busy;
    assign done            = w_done;
    assign match_count     = r_match;
    assign mismatch_count  = r_mismatch;
    assign first_err_valid = r_fe_vld;
    assign first_err_index = r_fe_idx;
    assign first_err_out   = r_fe_out;
    assign first_err_exp   = r_fe_exp;

endmodule
